// File: rtl/mod_exp_engine.sv
// Modular exponentiation core: result = base^exponent mod modulus, computed by
// right-to-left square-and-multiply with two interleaved (shift/add) modular multipliers.
module mod_exp_engine #(
    parameter int WIDTH     = 128,
    parameter int EXP_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL   = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     n_reg;
    logic [WIDTH-1:0]     r_reg;
    logic [WIDTH-1:0]     acc_a;
    logic [WIDTH-1:0]     acc_b;
    logic [EXP_WIDTH-1:0] e_reg;
    logic [CNT_W-1:0]     cnt;

    logic invalid;
    logic e_zero;
    logic e_last;

    // One interleaved multiplier step. Both acc and mcand are already reduced (< n),
    // so each of the doubling and the addition needs at most one subtract of n.
    function automatic logic [WIDTH-1:0] mod_step(
        input logic [WIDTH-1:0] acc,
        input logic             bit_set,
        input logic [WIDTH-1:0] mcand,
        input logic [WIDTH-1:0] n
    );
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] nx;
        nx = {2'b00, n};
        t  = {1'b0, acc, 1'b0};
        if (t >= nx)
            t = t - nx;
        if (bit_set) begin
            t = t + {2'b00, mcand};
            if (t >= nx)
                t = t - nx;
        end
        return t[WIDTH-1:0];
    endfunction

    assign invalid = (n_reg < WIDTH'(2)) || (b_reg >= n_reg);
    assign e_zero  = (e_reg == '0);
    assign e_last  = (e_reg[EXP_WIDTH-1:1] == '0);

    assign busy = (state == CHECK) || (state == MUL) || (state == STEP);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = (invalid || e_zero) ? DONE : MUL;
            MUL:     if (cnt == '0) state_next = STEP;
            STEP:    state_next = e_last ? DONE : MUL;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_reg  <= '0;
            n_reg  <= '0;
            r_reg  <= '0;
            acc_a  <= '0;
            acc_b  <= '0;
            e_reg  <= '0;
            cnt    <= '0;
            error  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        b_reg <= base;
                        e_reg <= exponent;
                        n_reg <= modulus;
                    end
                end
                CHECK: begin
                    r_reg <= WIDTH'(1);
                    acc_a <= '0;
                    acc_b <= '0;
                    cnt   <= CNT_TOP;
                    error <= invalid;
                    if (invalid)
                        result <= '0;
                    else if (e_zero)
                        result <= WIDTH'(1);
                end
                MUL: begin
                    // Unit A: R*B mod N, unit B: B*B mod N, multiplier scanned MSB-first
                    acc_a <= mod_step(acc_a, r_reg[cnt], b_reg, n_reg);
                    acc_b <= mod_step(acc_b, b_reg[cnt], b_reg, n_reg);
                    cnt   <= cnt - CNT_W'(1);
                end
                STEP: begin
                    if (e_reg[0])
                        r_reg <= acc_a;
                    b_reg <= acc_b;
                    e_reg <= e_reg >> 1;
                    acc_a <= '0;
                    acc_b <= '0;
                    cnt   <= CNT_TOP;
                    if (e_last)
                        result <= e_reg[0] ? acc_a : r_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboard bench for mod_exp_engine: stimulus pushes expected result/error/done-edge,
// a negedge monitor pops and compares whenever done is presented.
module tb_mod_exp_engine;

    localparam int W  = 128;
    localparam int EW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  base = '0;
    logic [EW-1:0] exponent = '0;
    logic [W-1:0]  modulus = '0;
    logic          busy;
    logic          done;
    logic          error;
    logic [W-1:0]  result;

    always #5 clk = ~clk;

    mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .result   (result)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           edge_no;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // cyc = number of rising edges so far; at a negedge the next edge is cyc+1
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [EW-1:0] e,
                                                input logic [W-1:0] n);
        logic [2*W-1:0] r, x, nn;
        r  = 1;
        x  = {{W{1'b0}}, b};
        nn = {{W{1'b0}}, n};
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 result=%0h want no done", result);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("error", W'(error), W'(mon_e.err));
                check("done_edge", W'(cyc + 1), W'(mon_e.edge_no));
                check("busy_with_done", W'(busy), '0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30000) begin
            total++;
            bad++;
            $display("FAIL timeout_idle: got busy=%0b done=%0b want idle", busy, done);
        end
    endtask

    task automatic do_op(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] n);
        exp_t x;
        int   k;
        wait_idle();
        base     = b;
        exponent = e;
        modulus  = n;
        start    = 1'b1;
        x.err = (n < 2) || (b >= n);
        k = 0;
        for (int i = 0; i < EW; i++) if (e[i]) k = i + 1;
        if (x.err) begin
            x.res = '0;
            k = 0;
        end else begin
            x.res = ref_modexp(b, e, n);
        end
        x.edge_no = cyc + 1 + 2 + k * (W + 1);
        sb.push_back(x);
        @(negedge clk);
        start    = 1'b0;
        base     = rnd128();
        exponent = rnd128();
        modulus  = rnd128();
    endtask

    initial begin
        logic [W-1:0]  rn, rb;
        logic [EW-1:0] re;

        repeat (3) @(negedge clk);
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
        check("reset_error", W'(error), '0);
        check("reset_result", result, '0);
        reset = 1'b1;

        do_op(920, 17, 2773);
        do_op(948, 157, 2773);
        do_op(5, 0, 2773);
        do_op(0, 17, 2773);
        do_op(2773, 17, 2773);
        do_op(5, 17, 1);
        do_op(920, 17, 2773);

        // second start during busy must be ignored
        do_op(920, 17, 2773);
        repeat (10) @(negedge clk);
        base = 7; exponent = 3; modulus = 11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // abort mid-multiply
        do_op(948, 157, 2773);
        repeat (50) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        #1;
        check("abort_busy", W'(busy), '0);
        check("abort_done", W'(done), '0);
        check("abort_result", result, '0);
        check("abort_error", W'(error), '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_op(920, 17, 2773);

        for (int it = 0; it < 14; it++) begin
            rn = (it % 3 == 0) ? W'($urandom_range(2, 65535)) : rnd128();
            if (rn == 0) rn = 3;
            rb = rnd128() % rn;
            if (it == 5) rb = rn;
            if (it == 9) rn = 1;
            re = (it == 7) ? '0 : EW'($urandom_range(1, 4095));
            do_op(rb, re, rn);
        end

        rn = rnd128() | {1'b1, {(W-1){1'b0}}};
        rb = rnd128() % rn;
        re = rnd128() | {1'b1, {(EW-1){1'b0}}};
        do_op(rb, re, rn);

        wait_idle();
        check("scoreboard_drained", W'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
